inst_encoder: RTL and testbench

//  Debug-side instruction encoder: the assembling counterpart of the controller's decoder. Accepts

---
 rtl/inst_encoder_if.sv | 34 +++
 rtl/inst_encoder.sv | 100 ++++++++++
 tb/tb_inst_encoder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_if.sv
// Request/instruction bus of the debug-side instruction encoder.
// valid/ready: a transfer happens on a rising edge where both are high; a source holds its
// payload and valid stable until that edge, and ready may depend combinationally on state only.
interface inst_encoder_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [4:0]       req_rs;
  logic [4:0]       req_rt;
  logic [4:0]       req_rd;
  logic [15:0]      req_imm;
  logic [25:0]      req_target;
  logic             inst_valid;
  logic             inst_ready;
  logic [31:0]      inst;
  logic             enc_err;
  logic [CNT_W-1:0] enc_count;
  logic [LW-1:0]    level;

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_rd, req_imm, req_target, inst_ready,
    input  req_ready, inst_valid, inst, enc_err, enc_count, level
  );

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_rd, req_imm, req_target, inst_ready,
    output req_ready, inst_valid, inst, enc_err, enc_count, level
  );
endinterface

// File: rtl/inst_encoder.sv
// Assembles mnemonic+operand requests into 32-bit MIPS words and queues them in a small FIFO
// for the instruction-injection path.
module inst_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  inst_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [31:0]      mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [LW-1:0]    level_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  logic [31:0] word;
  logic        supported;
  logic        accept;
  logic        push;
  logic        pop;

  always_comb begin
    word      = '0;
    supported = 1'b1;
    case (bus.req_op)
      4'd0:  word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h20};
      4'd1:  word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h22};
      4'd2:  word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h24};
      4'd3:  word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h25};
      4'd4:  word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h2A};
      4'd5:  word = {6'h00, bus.req_rs, 5'd0, 5'd0, 5'd0, 6'h08};
      4'd6:  word = {6'h02, bus.req_target};
      4'd7:  word = {6'h03, bus.req_target};
      4'd8:  word = {6'h04, bus.req_rs, bus.req_rt, bus.req_imm};
      4'd9:  word = {6'h08, bus.req_rs, bus.req_rt, bus.req_imm};
      4'd10: word = {6'h0C, bus.req_rs, bus.req_rt, bus.req_imm};
      4'd11: word = {6'h0D, bus.req_rs, bus.req_rt, bus.req_imm};
      4'd12: word = {6'h23, bus.req_rs, bus.req_rt, bus.req_imm};
      4'd13: word = {6'h2B, bus.req_rs, bus.req_rt, bus.req_imm};
      default: supported = 1'b0;
    endcase
  end

  // No full-bypass: a pop in the same cycle does not open a slot for a push.
  assign bus.req_ready  = (level_q < LW'(DEPTH)) && !flush;
  assign accept         = bus.req_valid && bus.req_ready;
  assign push           = accept && supported;
  assign pop            = bus.inst_valid && bus.inst_ready && !flush;

  assign bus.inst_valid = (level_q != '0);
  assign bus.inst       = mem[rd_ptr];
  assign bus.enc_err    = err_q;
  assign bus.enc_count  = count_q;
  assign bus.level      = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // The counter survives flush; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) count_q <= count_q + 1'b1;
      err_q <= accept && !supported;
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// Randomized and directed bench for inst_encoder against a queue-based reference model.
module tb_inst_encoder;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  inst_encoder_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus();

  inst_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  // scoreboard / reference model state
  logic [31:0]      exp_q[$];
  logic [CNT_W-1:0] m_count = '0;
  bit               m_err = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Encoding from the instruction tables: opcode/funct placed by field position arithmetic.
  function automatic logic [31:0] ref_encode(input int op, input longint rs, input longint rt,
                                             input longint rd, input longint imm,
                                             input longint tgt, output bit ok);
    longint funct [5] = '{'h20, 'h22, 'h24, 'h25, 'h2A};
    longint iop   [6] = '{'h04, 'h08, 'h0C, 'h0D, 'h23, 'h2B};
    longint v;
    ok = 1'b1;
    if (op <= 4)       v = rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + funct[op];
    else if (op == 5)  v = rs * (1 << 21) + 8;
    else if (op == 6)  v = 2 * (64'd1 << 26) + tgt;
    else if (op == 7)  v = 3 * (64'd1 << 26) + tgt;
    else if (op <= 13) v = iop[op-8] * (64'd1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
    else begin
      ok = 1'b0;
      v  = 0;
    end
    return v[31:0];
  endfunction

  task automatic drive_req(input bit rv, input int op, input int rs, input int rt, input int rd,
                           input int imm, input int tgt);
    bus.req_valid  = rv;
    bus.req_op     = 4'(op);
    bus.req_rs     = 5'(rs);
    bus.req_rt     = 5'(rt);
    bus.req_rd     = 5'(rd);
    bus.req_imm    = 16'(imm);
    bus.req_target = 26'(tgt);
  endtask

  task automatic compare_all();
    check("level", 32'(bus.level), 32'(exp_q.size()));
    check("inst_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
    check("req_ready", 32'(bus.req_ready), 32'((exp_q.size() < DEPTH) && !flush));
    check("enc_err", 32'(bus.enc_err), 32'(m_err));
    check("enc_count", 32'(bus.enc_count), 32'(m_count));
    if (exp_q.size() != 0) check("inst", bus.inst, exp_q[0]);
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic cycle();
    bit acc, pp, ok;
    logic [31:0] w;
    @(posedge clk);
    acc = bus.req_valid && (exp_q.size() < DEPTH) && !flush;
    pp  = (exp_q.size() != 0) && bus.inst_ready && !flush;
    w   = ref_encode(int'(bus.req_op), longint'(bus.req_rs), longint'(bus.req_rt),
                     longint'(bus.req_rd), longint'(bus.req_imm), longint'(bus.req_target), ok);
    if (flush) exp_q.delete();
    else begin
      if (pp) void'(exp_q.pop_front());
      if (acc && ok) begin
        exp_q.push_back(w);
        m_count++;
      end
    end
    m_err = acc && !ok;
    #1;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_level"}, 32'(bus.level), 32'd0);
    check({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'd0);
    check({tag, "_inst"}, bus.inst, 32'd0);
    check({tag, "_enc_err"}, 32'(bus.enc_err), 32'd0);
    check({tag, "_enc_count"}, 32'(bus.enc_count), 32'd0);
  endtask

  initial begin
    drive_req(1'b0, 0, 0, 0, 0, 0, 0);
    bus.inst_ready = 1'b0;
    #12;
    check_reset_values("rst");
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // ADD r3 = r1 + r2
    drive_req(1'b1, 0, 1, 2, 3, 0, 0);
    cycle();
    check("add_word", bus.inst, 32'h00221820);
    check("add_valid", 32'(bus.inst_valid), 32'd1);
    check("add_count", 32'(bus.enc_count), 32'd1);
    drive_req(1'b0, 0, 0, 0, 0, 0, 0);
    bus.inst_ready = 1'b1;
    cycle();

    // LW / SW / J known encodings
    bus.inst_ready = 1'b0;
    drive_req(1'b1, 12, 29, 8, 0, 'h0004, 0);
    cycle();
    check("lw_word", bus.inst, 32'h8FA80004);
    drive_req(1'b1, 13, 29, 8, 0, 'h0004, 0);
    bus.inst_ready = 1'b1;
    cycle();
    check("sw_word", bus.inst, 32'hAFA80004);
    drive_req(1'b1, 6, 0, 0, 0, 0, 'h100);
    cycle();
    check("j_word", bus.inst, 32'h08000100);
    drive_req(1'b0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Fill to full, fifth request held until a pop frees a slot
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b1, 1, i + 4, i + 5, i + 6, 0, 0);
      cycle();
    end
    check("full_level", 32'(bus.level), 32'd4);
    check("full_ready", 32'(bus.req_ready), 32'd0);
    bus.inst_ready = 1'b1;
    cycle();
    check("full_pushpop_level", 32'(bus.level), 32'd3);
    bus.inst_ready = 1'b0;
    cycle();
    check("fifth_level", 32'(bus.level), 32'd4);
    drive_req(1'b0, 0, 0, 0, 0, 0, 0);
    bus.inst_ready = 1'b1;
    repeat (5) cycle();

    // Half-full push+pop keeps level constant
    bus.inst_ready = 1'b0;
    drive_req(1'b1, 9, 3, 4, 0, 'h1234, 0);
    repeat (2) cycle();
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b1, 10 + i, i, i + 1, 0, 'hBEEF + i, 0);
      cycle();
      check("half_level", 32'(bus.level), 32'd2);
    end

    // Unsupported op pulses enc_err once
    drive_req(1'b1, 14, 1, 1, 1, 1, 1);
    bus.inst_ready = 1'b0;
    cycle();
    check("err_pulse", 32'(bus.enc_err), 32'd1);
    check("err_level", 32'(bus.level), 32'd2);
    drive_req(1'b1, 11, 7, 8, 0, 'h00FF, 0);
    cycle();
    check("err_clear", 32'(bus.enc_err), 32'd0);

    // Flush with 3 queued and a concurrent push
    drive_req(1'b0, 0, 0, 0, 0, 0, 0);
    bus.inst_ready = 1'b1;
    repeat (4) cycle();
    bus.inst_ready = 1'b0;
    drive_req(1'b1, 3, 9, 10, 11, 0, 0);
    repeat (3) cycle();
    flush = 1'b1;
    bus.inst_ready = 1'b1;
    cycle();
    flush = 1'b0;
    #1;
    check("flush_level", 32'(bus.level), 32'd0);
    check("flush_valid", 32'(bus.inst_valid), 32'd0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      drive_req($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535),
                $urandom_range(0, (1 << 26) - 1));
      bus.inst_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 31) == 0;
      cycle();
    end
    flush = 1'b0;

    // Reset mid-stream with an unsupported op pending
    bus.inst_ready = 1'b0;
    drive_req(1'b1, 7, 0, 0, 0, 0, 'h3FFFFFF);
    repeat (2) cycle();
    drive_req(1'b1, 15, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    m_count = '0;
    m_err = 1'b0;
    @(posedge clk);
    #2;
    check_reset_values("midrst_hold");
    drive_req(1'b0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (2) cycle();
    drive_req(1'b1, 4, 5, 6, 7, 0, 0);
    bus.inst_ready = 1'b1;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
